// File: rtl/id_scan_pkg.sv
// Shared types and constants for the two-channel identifier scanner.
// Contains the recognizer state encoding, the ASCII class ranges and the class helpers.
package id_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALPHA = 2'd1,
    S_MATCH = 2'd3
  } state_t;

  localparam logic [7:0] CH_DIGIT_LO = 8'h30;
  localparam logic [7:0] CH_DIGIT_HI = 8'h39;
  localparam logic [7:0] CH_UPPER_LO = 8'h41;
  localparam logic [7:0] CH_UPPER_HI = 8'h5A;
  localparam logic [7:0] CH_LOWER_LO = 8'h61;
  localparam logic [7:0] CH_LOWER_HI = 8'h7A;

  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= CH_UPPER_LO) && (c <= CH_UPPER_HI)) ||
           ((c >= CH_LOWER_LO) && (c <= CH_LOWER_HI));
  endfunction

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CH_DIGIT_LO) && (c <= CH_DIGIT_HI);
  endfunction

endpackage

// File: rtl/id_step.sv
// Combinational identifier recognizer step: (state, char) -> (next state, hit).
// Encoding 2 of the state falls through to the idle behaviour.
module id_step
  import id_scan_pkg::*;
(
  input  state_t     i_cur_state,
  input  logic [7:0] i_char,
  output state_t     o_next_state,
  output logic       o_hit
);

  always_comb begin
    o_next_state = S_IDLE;
    o_hit        = 1'b0;
    if (is_letter(i_char)) begin
      o_next_state = S_ALPHA;
    end else if (is_digit(i_char) &&
                 ((i_cur_state == S_ALPHA) || (i_cur_state == S_MATCH))) begin
      o_next_state = S_MATCH;
      o_hit        = 1'b1;
    end
  end

endmodule

// File: rtl/id_scan_arbiter.sv
// Two-channel identifier scanner sharing one id_step datapath through a per-character grant.
// Define ID_SCAN_FIXED_PRIO_EN for fixed channel-0 priority instead of round-robin.
//
// Handshake: reqN_ready is a combinational grant; a character is consumed on the rising
// edge where reqN_valid && reqN_ready. A character presented with its clear is not consumed.
module id_scan_arbiter
  import id_scan_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  output logic             req1_ready,
  input  logic             clr0,
  input  logic             clr1,
  output logic             hit_valid,
  output logic             hit_chan,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [1:0]       o_dbg_ctx0,
  output logic [1:0]       o_dbg_ctx1
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_ctx0, r_ctx1, w_ctx0_nxt, w_ctx1_nxt;
  logic [CNT_W-1:0] r_cnt0, r_cnt1, w_cnt0_nxt, w_cnt1_nxt;
  logic             r_hit_valid, r_hit_chan;
  logic             w_elig0, w_elig1, w_grant0, w_grant1, w_any_grant;
  state_t           w_cur_state, w_step_next;
  logic [7:0]       w_char;
  logic             w_step_hit;

  assign w_elig0 = req0_valid & ~clr0;
  assign w_elig1 = req1_valid & ~clr1;

`ifdef ID_SCAN_FIXED_PRIO_EN
  assign w_grant0 = w_elig0;
  assign w_grant1 = w_elig1 & ~w_elig0;
`else
  logic r_last_grant;

  // On contention the channel that did not win last time gets the grant.
  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
    end else if (w_any_grant) begin
      r_last_grant <= w_grant1;
    end
  end
`endif

  assign w_any_grant = w_grant0 | w_grant1;
  assign req0_ready  = w_grant0;
  assign req1_ready  = w_grant1;

  // Single shared recognizer, fed by whichever channel holds the grant.
  assign w_cur_state = w_grant1 ? r_ctx1 : r_ctx0;
  assign w_char      = w_grant1 ? req1_char : req0_char;

  id_step u_step (
    .i_cur_state  (w_cur_state),
    .i_char       (w_char),
    .o_next_state (w_step_next),
    .o_hit        (w_step_hit)
  );

  always_comb begin
    w_ctx0_nxt = r_ctx0;
    w_ctx1_nxt = r_ctx1;
    w_cnt0_nxt = r_cnt0;
    w_cnt1_nxt = r_cnt1;
    if (clr0) begin
      w_ctx0_nxt = S_IDLE;
      w_cnt0_nxt = '0;
    end else if (w_grant0) begin
      w_ctx0_nxt = w_step_next;
      if (w_step_hit && (r_cnt0 != CNT_MAX)) w_cnt0_nxt = r_cnt0 + CNT_W'(1);
    end
    if (clr1) begin
      w_ctx1_nxt = S_IDLE;
      w_cnt1_nxt = '0;
    end else if (w_grant1) begin
      w_ctx1_nxt = w_step_next;
      if (w_step_hit && (r_cnt1 != CNT_MAX)) w_cnt1_nxt = r_cnt1 + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctx0      <= S_IDLE;
      r_ctx1      <= S_IDLE;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
      r_hit_valid <= 1'b0;
      r_hit_chan  <= 1'b0;
    end else begin
      r_ctx0      <= w_ctx0_nxt;
      r_ctx1      <= w_ctx1_nxt;
      r_cnt0      <= w_cnt0_nxt;
      r_cnt1      <= w_cnt1_nxt;
      r_hit_valid <= w_any_grant & w_step_hit;
      if (w_any_grant) r_hit_chan <= w_grant1;
    end
  end

  assign hit_valid  = r_hit_valid;
  assign hit_chan   = r_hit_chan;
  assign cnt0       = r_cnt0;
  assign cnt1       = r_cnt1;
  assign o_dbg_ctx0 = r_ctx0;
  assign o_dbg_ctx1 = r_ctx1;

endmodule

// File: tb/tb_id_scan_arbiter.sv
// Randomized and directed bench for id_scan_arbiter with a scoreboard of expected hits.
// Expected hits are tagged with the cycle they must appear in and the owning channel.
module tb_id_scan_arbiter;

  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int M_IDLE  = 0;
  localparam int M_ALPHA = 1;
  localparam int M_MATCH = 3;
  localparam int QW      = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]    req0_char = 8'h00, req1_char = 8'h00;
  logic          clr0 = 1'b0, clr1 = 1'b0;
  logic          req0_ready, req1_ready, hit_valid, hit_chan;
  logic [CW-1:0] cnt0, cnt1;
  logic [1:0]    dbg_ctx0, dbg_ctx1;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;

  // Reference model: per-channel state, count, round-robin memory, last hit channel.
  int m_ctx[2];
  int m_cnt[2];
  int m_last;
  int m_hc;

  logic [QW-1:0] exp_q[$];

  id_scan_arbiter #(.CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_char  (req0_char),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_char  (req1_char),
    .req1_ready (req1_ready),
    .clr0       (clr0),
    .clr1       (clr1),
    .hit_valid  (hit_valid),
    .hit_chan   (hit_chan),
    .cnt0       (cnt0),
    .cnt1       (cnt1),
    .o_dbg_ctx0 (dbg_ctx0),
    .o_dbg_ctx1 (dbg_ctx1)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ctx[0] = M_IDLE; m_ctx[1] = M_IDLE;
    m_cnt[0] = 0;      m_cnt[1] = 0;
    m_last   = 1;
    m_hc     = 0;
  endtask

  function automatic void ref_step(input int st, input logic [7:0] c,
                                   output int ns, output bit h);
    bit letter, digit;
    letter = ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
    digit  = (c >= 8'h30) && (c <= 8'h39);
    h  = 1'b0;
    ns = M_IDLE;
    if (letter) ns = M_ALPHA;
    else if (digit && (st == M_ALPHA || st == M_MATCH)) begin
      ns = M_MATCH;
      h  = 1'b1;
    end
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; applies one cycle of inputs and advances the model.
  task automatic step(input bit v0, input logic [7:0] c0, input bit v1, input logic [7:0] c1,
                      input bit k0, input bit k1);
    bit e0, e1, g0, g1, h;
    int ch, ns;
    int n_ctx[2];
    int n_cnt[2];
    logic [7:0] c;
    req0_valid = v0; req0_char = c0; req1_valid = v1; req1_char = c1;
    clr0 = k0; clr1 = k1;
    #1;
    e0 = v0 && !k0;
    e1 = v1 && !k1;
    if (e0 && e1) begin
`ifdef ID_SCAN_FIXED_PRIO_EN
      g0 = 1'b1;
`else
      g0 = (m_last == 1);
`endif
      g1 = !g0;
    end else begin
      g0 = e0;
      g1 = e1;
    end
    chk("req0_ready", int'(req0_ready), int'(g0));
    chk("req1_ready", int'(req1_ready), int'(g1));
    n_ctx = m_ctx;
    n_cnt = m_cnt;
    if (g0 || g1) begin
      ch = g1 ? 1 : 0;
      c  = g1 ? c1 : c0;
      ref_step(m_ctx[ch], c, ns, h);
      n_ctx[ch] = ns;
      if (h) begin
        if (n_cnt[ch] < CNT_MAX) n_cnt[ch] = n_cnt[ch] + 1;
        exp_q.push_back({16'(cyc + 1), ch[0]});
      end
    end
    if (k0) begin n_ctx[0] = M_IDLE; n_cnt[0] = 0; end
    if (k1) begin n_ctx[1] = M_IDLE; n_cnt[1] = 0; end
    @(posedge clk);
    m_ctx = n_ctx;
    m_cnt = n_cnt;
    if (g0 || g1) begin
      m_last = ch;
      m_hc   = ch;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_hit_valid"}, int'(hit_valid), 0);
    chk({tag, "_hit_chan"},  int'(hit_chan),  0);
    chk({tag, "_cnt0"},      int'(cnt0),      0);
    chk({tag, "_cnt1"},      int'(cnt1),      0);
    chk({tag, "_ctx0"},      int'(dbg_ctx0),  M_IDLE);
    chk({tag, "_ctx1"},      int'(dbg_ctx1),  M_IDLE);
  endtask

  // Asserted between edges; outputs must fall before the next edge.
  task automatic async_reset();
    #2 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    exp_q.delete();
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic logic [7:0] rnd_char();
    case ($urandom_range(0, 5))
      0: return 8'(8'h61 + $urandom_range(0, 25));
      1: return 8'(8'h41 + $urandom_range(0, 25));
      2, 3: return 8'(8'h30 + $urandom_range(0, 9));
      4: return 8'h2B;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [QW-1:0] e;
    if (mon_en && !reset) begin
      chk("cnt0", int'(cnt0), m_cnt[0]);
      chk("cnt1", int'(cnt1), m_cnt[1]);
      chk("ctx0", int'(dbg_ctx0), m_ctx[0]);
      chk("ctx1", int'(dbg_ctx1), m_ctx[1]);
      chk("hit_chan", int'(hit_chan), m_hc);
      if (hit_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_hit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("hit_cycle", cyc, int'(e[QW-1:1]));
          chk("hit_tag_chan", int'(hit_chan), int'(e[0]));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][QW-1:1]) <= cyc) begin
        e = exp_q.pop_front();
        chk("missed_hit", 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset  = 1'b0;
    mon_en = 1'b1;

    // ch0 "a12": hits on both digits
    step(1'b1, "a", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "1", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "2", 1'b0, 8'h00, 1'b0, 1'b0);
    idle(2);
    chk("plan1_cnt0", int'(cnt0), 2);

    // interleaved contention: each char held until accepted
    step(1'b1, "x", 1'b1, "y", 1'b0, 1'b0);
    step(1'b1, "x", 1'b1, "y", 1'b0, 1'b0);
    step(1'b1, "5", 1'b1, "7", 1'b0, 1'b0);
    step(1'b1, "5", 1'b1, "7", 1'b0, 1'b0);
    idle(2);

    // ch0 "1b+3": no hits, ends idle
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, "1", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "b", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "+", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "3", 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    chk("plan3_cnt0", int'(cnt0), 0);

    // saturation on ch1: "q" then five "9"
    step(1'b0, 8'h00, 1'b1, "q", 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, "q", 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, "9", 1'b0, 1'b0);
    idle(1);
    chk("plan4_cnt1_sat", int'(cnt1), CNT_MAX);

    // clear wins over valid; other channel still granted
    step(1'b1, "k", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "4", 1'b1, "m", 1'b1, 1'b0);
    step(1'b1, "4", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "4", 1'b1, "4", 1'b1, 1'b1);
    idle(1);

    // async reset with an in-flight hit
    step(1'b1, "a", 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, "1", 1'b0, 8'h00, 1'b0, 1'b0);
    async_reset();
    step(1'b1, "5", 1'b0, 8'h00, 1'b0, 1'b0);
    idle(1);
    chk("post_rst_cnt0", int'(cnt0), 0);

    // contention for 3 cycles (fixed-priority build keeps ch0)
    for (int i = 0; i < 3; i++) step(1'b1, "z", 1'b1, "w", 1'b0, 1'b0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd_char(),
           1'($urandom_range(0, 3) != 0), rnd_char(),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 19) == 0));
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
